// File: rtl/fifo_arb_pkg.sv
// Shared types and helpers for the FIFO write-port arbiter.
package fifo_arb_pkg;

  typedef enum logic {
    StIdle   = 1'b0,
    StLocked = 1'b1
  } arb_state_e;

  localparam int unsigned DefaultN     = 2;
  localparam int unsigned DefaultWidth = 8;

  // Increment a requester index, wrapping from n-1 back to 0.
  function automatic int unsigned wrap_inc(input int unsigned idx, input int unsigned n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or after rr_ptr_i, modulo N.
module fifo_wr_arbiter_rr_pick #(
  parameter int unsigned N   = 2,
  parameter int unsigned IDW = 1
) (
  input  logic [N-1:0]   req_i,
  input  logic [IDW-1:0] rr_ptr_i,
  output logic           valid_o,
  output logic [IDW-1:0] winner_o
);

  logic [N-1:0] rot;

  // Rotate so bit 0 is the requester at rr_ptr_i, then take the lowest set bit.
  always_comb begin
    int unsigned sum;
    rot      = N'({req_i, req_i} >> rr_ptr_i);
    valid_o  = 1'b0;
    winner_o = '0;
    sum      = 0;
    for (int k = N - 1; k >= 0; k--) begin
      if (rot[k]) begin
        sum = 32'(rr_ptr_i) + 32'(k);
        if (sum >= N) sum = sum - N;
        valid_o  = 1'b1;
        winner_o = IDW'(sum);
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port between N packet requesters.
// Optional owner-stall watchdog enabled by defining FIFO_ARB_WATCHDOG_EN.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int unsigned N      = DefaultN,
  parameter int unsigned WIDTH  = DefaultWidth,
  parameter int unsigned IDW    = (N > 1) ? $clog2(N) : 1,
  parameter int unsigned WD_CYC = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N-1:0]       req,
  input  logic [N*WIDTH-1:0] req_data,
  input  logic [N-1:0]       req_last,
  output logic [N-1:0]       req_ack,
  input  logic               fifo_full,
  output logic               fifo_write_flag,
  output logic [WIDTH-1:0]   fifo_write_data,
  output logic [IDW-1:0]     grant_id,
  output logic               busy,
  output logic               wd_err
);

  arb_state_e     state_q, state_d;
  logic [IDW-1:0] rr_ptr_q, rr_ptr_d;
  logic [IDW-1:0] owner_q, owner_d;
  logic [IDW-1:0] grant_id_q, grant_id_d;
  logic           pick_valid;
  logic [IDW-1:0] pick_id;
  logic [WIDTH-1:0] data_arr [N];

`ifdef FIFO_ARB_WATCHDOG_EN
  localparam int unsigned WdW = (WD_CYC > 2) ? $clog2(WD_CYC) : 1;
  logic [WdW-1:0] wd_cnt_q, wd_cnt_d;
  logic           wd_err_q, wd_err_d;
  assign wd_err = wd_err_q;
`else
  logic unused_wd_cyc;
  assign unused_wd_cyc = ^WD_CYC;
  assign wd_err = 1'b0;
`endif

  for (genvar g = 0; g < N; g++) begin : g_unpack
    assign data_arr[g] = req_data[g*WIDTH +: WIDTH];
  end

  fifo_wr_arbiter_rr_pick #(
    .N   (N),
    .IDW (IDW)
  ) u_rr_pick (
    .req_i    (req),
    .rr_ptr_i (rr_ptr_q),
    .valid_o  (pick_valid),
    .winner_o (pick_id)
  );

  assign busy     = (state_q == StLocked);
  assign grant_id = grant_id_q;

  // Next-state and write-port drive; outputs forced low while reset is held.
  always_comb begin
    state_d         = state_q;
    rr_ptr_d        = rr_ptr_q;
    owner_d         = owner_q;
    grant_id_d      = grant_id_q;
    req_ack         = '0;
    fifo_write_flag = 1'b0;
    fifo_write_data = '0;
`ifdef FIFO_ARB_WATCHDOG_EN
    wd_cnt_d        = wd_cnt_q;
    wd_err_d        = 1'b0;
`endif
    unique case (state_q)
      StIdle: begin
        if (pick_valid && !fifo_full) begin
          req_ack[pick_id] = 1'b1;
          fifo_write_flag  = 1'b1;
          fifo_write_data  = data_arr[pick_id];
          grant_id_d       = pick_id;
`ifdef FIFO_ARB_WATCHDOG_EN
          wd_cnt_d         = '0;
`endif
          if (req_last[pick_id]) begin
            rr_ptr_d = IDW'(wrap_inc(32'(pick_id), N));
          end else begin
            state_d = StLocked;
            owner_d = pick_id;
          end
        end
      end
      StLocked: begin
        if (req[owner_q] && !fifo_full) begin
          req_ack[owner_q] = 1'b1;
          fifo_write_flag  = 1'b1;
          fifo_write_data  = data_arr[owner_q];
`ifdef FIFO_ARB_WATCHDOG_EN
          wd_cnt_d         = '0;
`endif
          if (req_last[owner_q]) begin
            state_d  = StIdle;
            rr_ptr_d = IDW'(wrap_inc(32'(owner_q), N));
          end
        end
`ifdef FIFO_ARB_WATCHDOG_EN
        // Only cycles where the owner itself is silent count; full stalls do not.
        else if (!req[owner_q]) begin
          if (wd_cnt_q == WdW'(WD_CYC - 1)) begin
            state_d  = StIdle;
            rr_ptr_d = IDW'(wrap_inc(32'(owner_q), N));
            wd_err_d = 1'b1;
            wd_cnt_d = '0;
          end else begin
            wd_cnt_d = wd_cnt_q + 1'b1;
          end
        end
`endif
      end
      default: state_d = StIdle;
    endcase
    if (!rst_n) begin
      req_ack         = '0;
      fifo_write_flag = 1'b0;
      fifo_write_data = '0;
    end
  end

  // Arbitration state register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      rr_ptr_q   <= '0;
      owner_q    <= '0;
      grant_id_q <= '0;
`ifdef FIFO_ARB_WATCHDOG_EN
      wd_cnt_q   <= '0;
      wd_err_q   <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      owner_q    <= owner_d;
      grant_id_q <= grant_id_d;
`ifdef FIFO_ARB_WATCHDOG_EN
      wd_cnt_q   <= wd_cnt_d;
      wd_err_q   <= wd_err_d;
`endif
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Scoreboard bench for fifo_wr_arbiter with three requesters.
module tb_fifo_wr_arbiter;

  localparam int unsigned N     = 3;
  localparam int unsigned WIDTH = 8;
  localparam int unsigned IDW   = 2;

  logic               clk = 1'b0;
  logic               rst_n;
  logic [N-1:0]       req;
  logic [N*WIDTH-1:0] req_data;
  logic [N-1:0]       req_last;
  logic [N-1:0]       req_ack;
  logic               fifo_full;
  logic               fifo_write_flag;
  logic [WIDTH-1:0]   fifo_write_data;
  logic [IDW-1:0]     grant_id;
  logic               busy;
  logic               wd_err;

  int n_cmp = 0;
  int n_err = 0;

  // Beats per requester: {last, data}
  logic [8:0] src0[$];
  logic [8:0] src1[$];
  logic [8:0] src2[$];
  logic [N-1:0] en;
  // Expected writes in order: id*256 + data
  int sb[$];

  always #5 clk = ~clk;

  fifo_wr_arbiter #(
    .N      (N),
    .WIDTH  (WIDTH),
    .WD_CYC (16)
  ) u_dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .req             (req),
    .req_data        (req_data),
    .req_last        (req_last),
    .req_ack         (req_ack),
    .fifo_full       (fifo_full),
    .fifo_write_flag (fifo_write_flag),
    .fifo_write_data (fifo_write_data),
    .grant_id        (grant_id),
    .busy            (busy),
    .wd_err          (wd_err)
  );

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic load(input int id, input logic [7:0] d, input logic l);
    case (id)
      0: src0.push_back({l, d});
      1: src1.push_back({l, d});
      default: src2.push_back({l, d});
    endcase
  endtask

  task automatic expect_wr(input int id, input logic [7:0] d);
    sb.push_back(id * 256 + int'(d));
  endtask

  task automatic drive();
    logic [8:0] h;
    req = '0;
    req_data = '0;
    req_last = '0;
    if (en[0] && src0.size() > 0) begin
      h = src0[0]; req[0] = 1'b1; req_data[7:0] = h[7:0]; req_last[0] = h[8];
    end
    if (en[1] && src1.size() > 0) begin
      h = src1[0]; req[1] = 1'b1; req_data[15:8] = h[7:0]; req_last[1] = h[8];
    end
    if (en[2] && src2.size() > 0) begin
      h = src2[0]; req[2] = 1'b1; req_data[23:16] = h[7:0]; req_last[2] = h[8];
    end
  endtask

  // One clock: score outputs at negedge, commit at posedge, retire acked beats.
  task automatic cycle();
    logic [N-1:0] ack_s;
    logic [8:0]   h;
    int           e;
    @(negedge clk);
    ack_s = req_ack;
    if (fifo_write_flag) begin
      if (sb.size() == 0) begin
        check_eq("unexpected_write", {24'd0, fifo_write_data}, 32'hffff_ffff);
      end else begin
        e = sb.pop_front();
        check_eq("wr_data", {24'd0, fifo_write_data}, {24'd0, e[7:0]});
        check_eq("wr_ack", {29'd0, req_ack}, 32'd1 << e[15:8]);
      end
    end else begin
      check_eq("idle_ack", {29'd0, req_ack}, 32'd0);
    end
    @(posedge clk);
    #1;
    if (ack_s[0]) h = src0.pop_front();
    if (ack_s[1]) h = src1.pop_front();
    if (ack_s[2]) h = src2.pop_front();
    drive();
  endtask

  initial begin
    rst_n = 1'b0;
    fifo_full = 1'b0;
    en = '1;
    load(0, 8'h11, 1'b1);
    drive();
    repeat (3) cycle();
    check_eq("rst_busy", {31'd0, busy}, 32'd0);
    check_eq("rst_grant", {30'd0, grant_id}, 32'd0);
    check_eq("rst_wd_err", {31'd0, wd_err}, 32'd0);
    src0.delete();
    rst_n = 1'b1;
    drive();

    // Single-beat packets from 0 and 1 alternate
    load(0, 8'h01, 1'b1); load(0, 8'h02, 1'b1);
    load(1, 8'h11, 1'b1); load(1, 8'h12, 1'b1);
    expect_wr(0, 8'h01); expect_wr(1, 8'h11); expect_wr(0, 8'h02); expect_wr(1, 8'h12);
    drive();
    for (int i = 0; i < 4; i++) begin
      cycle();
      check_eq("alt_busy", {31'd0, busy}, 32'd0);
    end
    check_eq("alt_grant", {30'd0, grant_id}, 32'd1);

    // 3-beat packet from 0 (pointer at 2 wraps to 0) while 1 waits
    load(0, 8'h0a, 1'b0); load(0, 8'h0b, 1'b0); load(0, 8'h0c, 1'b1);
    load(1, 8'h1d, 1'b1);
    expect_wr(0, 8'h0a); expect_wr(0, 8'h0b); expect_wr(0, 8'h0c); expect_wr(1, 8'h1d);
    drive();
    cycle(); check_eq("pkt_busy1", {31'd0, busy}, 32'd1);
    cycle(); check_eq("pkt_busy2", {31'd0, busy}, 32'd1);
    cycle(); check_eq("pkt_busy3", {31'd0, busy}, 32'd0);
    cycle(); check_eq("pkt_grant", {30'd0, grant_id}, 32'd1);

    // FIFO full holds everything; order afterwards follows the unchanged pointer
    load(0, 8'h30, 1'b1); load(1, 8'h31, 1'b1);
    fifo_full = 1'b1;
    drive();
    for (int i = 0; i < 3; i++) begin
      cycle();
      check_eq("full_busy", {31'd0, busy}, 32'd0);
      check_eq("full_grant", {30'd0, grant_id}, 32'd1);
    end
    fifo_full = 1'b0;
    expect_wr(0, 8'h30); expect_wr(1, 8'h31);
    cycle(); check_eq("full_release_grant", {30'd0, grant_id}, 32'd0);
    cycle();

    // All three requesting, pointer at 2
    load(0, 8'h50, 1'b1); load(1, 8'h51, 1'b1); load(2, 8'h52, 1'b1);
    expect_wr(2, 8'h52); expect_wr(0, 8'h50); expect_wr(1, 8'h51);
    drive();
    repeat (3) cycle();

    // Owner stalls mid-packet; nobody else is served
    load(0, 8'h60, 1'b0); load(0, 8'h61, 1'b1); load(1, 8'h70, 1'b1);
    expect_wr(0, 8'h60);
    drive();
    cycle();
    en[0] = 1'b0;
    drive();
    repeat (5) cycle();
    check_eq("stall_busy", {31'd0, busy}, 32'd1);
    en[0] = 1'b1;
    drive();
    expect_wr(0, 8'h61); expect_wr(1, 8'h70);
    repeat (2) cycle();

    // Reset in the middle of a packet
    load(0, 8'h80, 1'b0); load(0, 8'h81, 1'b0); load(0, 8'h82, 1'b1);
    load(1, 8'h90, 1'b1);
    expect_wr(0, 8'h80);
    drive();
    cycle();
    rst_n = 1'b0;
    repeat (2) begin
      @(negedge clk);
      check_eq("rst_mid_flag", {31'd0, fifo_write_flag}, 32'd0);
      check_eq("rst_mid_ack", {29'd0, req_ack}, 32'd0);
      cycle();
    end
    check_eq("rst_mid_busy", {31'd0, busy}, 32'd0);
    check_eq("rst_mid_grant", {30'd0, grant_id}, 32'd0);
    src0.delete();
    load(2, 8'ha2, 1'b1);
    rst_n = 1'b1;
    drive();
    expect_wr(1, 8'h90); expect_wr(2, 8'ha2);
    repeat (2) cycle();

    // Owner goes silent long enough to trip the watchdog, if present
    load(0, 8'hb0, 1'b0); load(0, 8'hb1, 1'b1); load(1, 8'hc1, 1'b1);
    expect_wr(0, 8'hb0);
    drive();
    cycle();
    en[0] = 1'b0;
    drive();
`ifdef FIFO_ARB_WATCHDOG_EN
    repeat (15) cycle();
    check_eq("wd_pre_busy", {31'd0, busy}, 32'd1);
    check_eq("wd_pre_err", {31'd0, wd_err}, 32'd0);
    cycle();
    check_eq("wd_busy", {31'd0, busy}, 32'd0);
    check_eq("wd_err", {31'd0, wd_err}, 32'd1);
    expect_wr(1, 8'hc1);
    cycle();
    check_eq("wd_err_pulse", {31'd0, wd_err}, 32'd0);
    en[0] = 1'b1;
    drive();
    expect_wr(0, 8'hb1);
    cycle();
`else
    repeat (20) cycle();
    check_eq("nowd_busy", {31'd0, busy}, 32'd1);
    check_eq("nowd_err", {31'd0, wd_err}, 32'd0);
    en[0] = 1'b1;
    drive();
    expect_wr(0, 8'hb1); expect_wr(1, 8'hc1);
    repeat (2) cycle();
`endif

    repeat (3) cycle();
    check_eq("sb_drained", sb.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
